// File: rtl/cyan_sprite_fetch.sv
// Sprite fetch stage for the cyan palette path.
// Maps each draw coordinate to a sprite ROM address, waits out the ROM
// latency, treats index 0 as transparent and applies the hit-flash override.
// Result: registered palette index plus an opaque flag, three cycles after
// the coordinate is sampled, one pixel per cycle.
module cyan_sprite_fetch #(
    parameter int         SPRITE_W     = 32,
    parameter int         SPRITE_H     = 32,
    parameter int         FLASH_FRAMES = 8,
    parameter logic [2:0] FLASH_INDEX  = 3'd2,
    parameter int         ROM_AW       = 11
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              flip_h,
    input  logic              anim_frame,
    input  logic              hit,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [2:0]        select_input,
    output logic              pixel_valid,
    output logic              flashing
);
    localparam int XW     = $clog2(SPRITE_W);
    localparam int YW     = $clog2(SPRITE_H);
    localparam int STAGES = 2;

    typedef enum logic {IDLE, FLASH} state_t;

    // Frame-latched sprite controls
    logic [9:0]        sx, sy;
    logic              flip_q, anim_q;

    // Address stage
    logic              in_box;
    logic [XW-1:0]     lx, lx_raw;
    logic [YW-1:0]     ly;
    logic [STAGES:1]   vld_pipe;

    // Flash FSM
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              hit_pending, hit_pending_n;
    logic              override;

    // Capture sprite position/controls only at frame start so a frame is drawn consistently
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx     <= '0;
            sy     <= '0;
            flip_q <= 1'b0;
            anim_q <= 1'b0;
        end else if (frame_start) begin
            sx     <= SpriteX;
            sy     <= SpriteY;
            flip_q <= flip_h;
            anim_q <= anim_frame;
        end
    end

    // Box test in 11 bits so a sprite near the right/bottom edge never wraps to column/row 0
    always_comb begin
        in_box = ({1'b0, DrawX} >= {1'b0, sx}) && ({1'b0, DrawX} < {1'b0, sx} + 11'(SPRITE_W)) &&
                 ({1'b0, DrawY} >= {1'b0, sy}) && ({1'b0, DrawY} < {1'b0, sy} + 11'(SPRITE_H));
        lx_raw = XW'(DrawX - sx);
        lx     = flip_q ? (XW'(SPRITE_W - 1) - lx_raw) : lx_raw;
        ly     = YW'(DrawY - sy);
    end

    // Register ROM address and carry the in-box flag alongside the ROM latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            vld_pipe <= '0;
        end else begin
            rom_addr <= in_box ? ROM_AW'({anim_q, ly, lx}) : '0;
            vld_pipe <= {vld_pipe[STAGES-1:1], in_box};
        end
    end

    // Output stage: index 0 is transparent, flash blink forces the flash index
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_valid  <= 1'b0;
            select_input <= '0;
        end else if (vld_pipe[STAGES] && rom_data != 3'd0) begin
            pixel_valid  <= 1'b1;
            select_input <= override ? FLASH_INDEX : rom_data;
        end else begin
            pixel_valid  <= 1'b0;
            select_input <= '0;
        end
    end

    // Flash FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hit_pending <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            hit_pending <= hit_pending_n;
        end
    end

    // Flash FSM next state: hits only take effect at frame start; a re-hit reloads the count
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        hit_pending_n = hit_pending | hit;
        if (frame_start) begin
            hit_pending_n = 1'b0;
            if (hit_pending | hit) begin
                state_n = FLASH;
                cnt_n   = 4'(FLASH_FRAMES);
            end else if (state == FLASH) begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
        end
    end

    assign override = (state == FLASH) && cnt[0];
    assign flashing = (state == FLASH);

endmodule

// File: tb/tb_cyan_sprite_fetch.sv
// Directed bench for cyan_sprite_fetch: vector table for the address/fetch
// path plus hand sequences for flash timing, shadowing and reset.
module tb_cyan_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic        flip_h = 1'b0, anim_frame = 1'b0, hit = 1'b0;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [2:0]  select_input;
    logic        pixel_valid, flashing;

    int checks = 0;
    int errors = 0;

    logic [2:0] rom_mem [0:2047];

    cyan_sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .flip_h(flip_h), .anim_frame(anim_frame), .hit(hit),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .select_input(select_input), .pixel_valid(pixel_valid), .flashing(flashing)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM model: one cycle latency
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        string      name;
        logic [9:0] sx, sy;
        logic       f, a;
        logic [9:0] dx, dy;
        logic       inbox;
        logic [2:0] rom;
        logic [10:0] exp_addr;
        logic       exp_valid;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic f,
                         input logic a, input logic h);
        @(negedge Clk);
        SpriteX = x; SpriteY = y; flip_h = f; anim_frame = a;
        frame_start = 1'b1; hit = h;
        @(negedge Clk);
        frame_start = 1'b0; hit = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 3'd0;
        rom_mem[0] = 3'd5;

        //           name         sx    sy   f  a   dx    dy   in rom addr  v  sel
        vecs[0]  = '{"origin",    100,  50, 0, 0, 100,  50, 1, 5, 0,    1, 5};
        vecs[1]  = '{"far_corner",100,  50, 0, 0, 131,  81, 1, 5, 1023, 1, 5};
        vecs[2]  = '{"right_out", 100,  50, 0, 0, 132,  81, 0, 0, 0,    0, 0};
        vecs[3]  = '{"flip_anim", 100,  50, 1, 1, 100,  50, 1, 6, 1055, 1, 6};
        vecs[4]  = '{"transp",    100,  50, 0, 0, 101,  50, 1, 0, 1,    0, 0};
        vecs[5]  = '{"edge_1023", 1000, 50, 0, 0, 1023, 50, 1, 3, 23,   1, 3};
        vecs[6]  = '{"no_wrap",   1000, 50, 0, 0, 5,    50, 0, 0, 0,    0, 0};
        vecs[7]  = '{"left_out",  100,  50, 0, 0, 99,   50, 0, 0, 0,    0, 0};
        vecs[8]  = '{"above_out", 100,  50, 0, 0, 100,  49, 0, 0, 0,    0, 0};
        vecs[9]  = '{"mid",       100,  50, 0, 0, 110,  60, 1, 7, 330,  1, 7};
        vecs[10] = '{"bottom",    0,    1000,0, 0, 0,   1023,1, 4, 736,  1, 4};
        vecs[11] = '{"flip_only", 100,  50, 1, 0, 105,  50, 1, 1, 26,   1, 1};

        // Reset state
        #12;
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_sel", 32'(select_input), 0);
        check("rst_flash", 32'(flashing), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Table-driven fetch vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].inbox) rom_mem[vecs[i].exp_addr] = vecs[i].rom;
            frame(vecs[i].sx, vecs[i].sy, vecs[i].f, vecs[i].a, 1'b0);
            DrawX = vecs[i].dx; DrawY = vecs[i].dy;
            @(posedge Clk); #1;
            check({vecs[i].name, "_addr"}, 32'(rom_addr), 32'(vecs[i].exp_addr));
            repeat (2) @(posedge Clk);
            #1;
            check({vecs[i].name, "_valid"}, 32'(pixel_valid), 32'(vecs[i].exp_valid));
            check({vecs[i].name, "_sel"}, 32'(select_input), 32'(vecs[i].exp_sel));
        end

        // Flash: hit mid-frame is deferred to next frame start
        frame(100, 50, 0, 0, 0);
        DrawX = 100; DrawY = 50;
        repeat (4) @(posedge Clk);
        #1;
        check("pre_flash_sel", 32'(select_input), 5);
        @(negedge Clk); hit = 1'b1;
        @(negedge Clk); hit = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("hit_deferred_flash", 32'(flashing), 0);
        check("hit_deferred_sel", 32'(select_input), 5);
        frame(100, 50, 0, 0, 0);
        settle();
        check("load_flash", 32'(flashing), 1);
        check("load_no_ovr", 32'(select_input), 5);
        for (int i = 1; i <= 8; i++) begin
            frame(100, 50, 0, 0, 0);
            settle();
            check($sformatf("count_%0d_flash", i), 32'(flashing), (i < 8) ? 1 : 0);
            check($sformatf("count_%0d_sel", i), 32'(select_input),
                  (i < 8 && ((8 - i) % 2) == 1) ? 2 : 5);
        end

        // Re-hit coincident with frame start at cnt = 3 reloads to 8
        frame(100, 50, 0, 0, 1);
        settle();
        check("cohit_flash", 32'(flashing), 1);
        check("cohit_no_ovr", 32'(select_input), 5);
        for (int i = 1; i <= 5; i++) frame(100, 50, 0, 0, 0);
        settle();
        check("cnt3_ovr", 32'(select_input), 2);
        frame(100, 50, 0, 0, 1);
        settle();
        check("rehit_no_ovr", 32'(select_input), 5);
        for (int i = 1; i <= 3; i++) frame(100, 50, 0, 0, 0);
        settle();
        check("rehit_cnt5_flash", 32'(flashing), 1);
        check("rehit_cnt5_sel", 32'(select_input), 2);
        for (int i = 1; i <= 5; i++) frame(100, 50, 0, 0, 0);
        settle();
        check("rehit_end_flash", 32'(flashing), 0);

        // Shadowing: sprite move without frame start has no effect
        DrawX = 100; DrawY = 50;
        @(negedge Clk); SpriteX = 90;
        repeat (3) @(posedge Clk);
        #1;
        check("shadow_addr", 32'(rom_addr), 0);
        check("shadow_sel", 32'(select_input), 5);

        // Reset mid-stream while flashing with a hit pending
        frame(100, 50, 0, 0, 1);
        @(negedge Clk); hit = 1'b1;
        @(negedge Clk); hit = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("pre_rst_valid", 32'(pixel_valid), 1);
        check("pre_rst_flash", 32'(flashing), 1);
        @(posedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        check("async_valid", 32'(pixel_valid), 0);
        check("async_sel", 32'(select_input), 0);
        check("async_addr", 32'(rom_addr), 0);
        check("async_flash", 32'(flashing), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check($sformatf("no_stale_%0d", i), 32'(pixel_valid), 0);
        end
        frame(100, 50, 0, 0, 0);
        settle();
        check("pending_cleared", 32'(flashing), 0);
        repeat (2) @(posedge Clk);
        #1;
        check("post_rst_sel", 32'(select_input), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
